fetch_unit: RTL

//  Instruction fetch stage directly upstream of the instruction decoder. Owns the PC, fetches
//  32-bit words over a valid/ack instruction-memory port, and buffers them in a 2-entry queue.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 58 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP reset value,
// FSM state type, queue entry layout and PC alignment helper.
package fetch_unit_pkg;

  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
  localparam int unsigned ENTRY_W      = 64;

  // S_IDLE : no request on the bus
  // S_REQ  : request at the current PC is on the bus
  // S_STALE: request on the bus was overtaken by a redirect; its data is dropped
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_STALE = 2'd2
  } fetch_state_e;

  // Queue entry: instruction word in the upper half, its PC in the lower half.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between the fetch bus and decode. The head entry is always
// driven on the output; flush empties it in one cycle. Push while full is only
// accepted when a pop happens in the same cycle.
module fetch_buffer #(
  parameter int unsigned       WIDTH     = 64,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= RESET_VAL;
      mem_q[1] <= RESET_VAL;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a
// time on the valid/ack memory port and queues results for decode.
// Memory handshake: once imem_valid_o is high, imem_addr_o and imem_valid_o hold
// until the cycle imem_ack_i is high; data is taken only in that ack cycle and
// the ack may arrive in the same cycle valid first rises. Decode handshake: an
// entry moves when instr_valid_o & instr_ready_i at a rising clock edge.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic [31:0]  imem_addr_o,
  output logic         imem_valid_o,
  input  logic         imem_ack_i,
  input  logic [31:0]  imem_data_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic [31:0]  instr_o,
  output logic [31:0]  instr_pc_o,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  output fetch_state_e state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;      // next address to fetch
  logic [31:0]  addr_q, addr_d;  // address currently driven on the bus
  logic         push;
  logic         pop;
  logic         flush;
  logic [1:0]   count;
  logic         full;
  logic         empty;
  logic [31:0]  redir_pc;
  logic [31:0]  next_pc;
  logic [2:0]   count_after_push;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign redir_pc         = word_align(redirect_pc_i);
  assign next_pc          = addr_q + 32'd4;
  assign pop              = instr_valid_o & instr_ready_i;
  assign count_after_push = {1'b0, count} + 3'd1 - {2'b00, pop};
  assign push_entry       = '{instr: imem_data_i, pc: addr_q};

  assign imem_addr_o   = addr_q;
  assign imem_valid_o  = (state_q != S_IDLE);
  assign instr_valid_o = ~empty;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;
  assign state_o       = state_q;

  // State, PC and bus address registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, PC update and queue control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    flush   = redirect_i;
    case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = S_REQ;
        end else if (!full) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            // Word is discarded; the new target goes out next cycle.
            pc_d   = redir_pc;
            addr_d = redir_pc;
          end else begin
            push   = 1'b1;
            pc_d   = next_pc;
            addr_d = next_pc;
            if (count_after_push >= 3'd2) begin
              state_d = S_IDLE;
            end
          end
        end else if (redirect_i) begin
          // Bus address must hold until ack, so remember the target only.
          pc_d    = redir_pc;
          state_d = S_STALE;
        end
      end
      S_STALE: begin
        if (redirect_i) begin
          pc_d = redir_pc;
        end
        if (imem_ack_i) begin
          addr_d  = redirect_i ? redir_pc : pc_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  fetch_buffer #(
    .WIDTH     (ENTRY_W),
    .RESET_VAL ({RV_NOP_INSTR, 32'h0000_0000})
  ) u_buffer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule
